// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared state encoding and byte-lane constants for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int         BYTE_LANES = 4;
    localparam logic [3:0] WE_READ    = 4'h0;
    localparam logic [3:0] WE_FULL    = 4'hF;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester bus, response bus and SRAM port of the arbiter
interface sram_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int ADDRW = 10
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*4-1:0]     req_we;
    logic [NREQ*32-1:0]    req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  init_done;
    logic                  mem_cs;
    logic [ADDRW-1:0]      mem_addr;
    logic [3:0]            mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, init_done,
               mem_cs, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done,
               mem_cs, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/sram_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o
);

    int  j;
    logic found;

    // scan N slots starting at ptr, wrapping, and keep the first active one
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one byte-writable SRAM with a zero-fill sweep after reset
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDRW      = 10,
    parameter int DATAW      = 32,
    parameter int INIT_DEPTH = 1024
) (
    input logic            clk,
    input logic            rstn,
    sram_arbiter_if.slave  bus
);

    localparam int PW   = $clog2(NREQ);
    localparam int LAST = (INIT_DEPTH > 0) ? INIT_DEPTH - 1 : 0;

    state_t             state_q;
    logic [ADDRW-1:0]   init_cnt_q;
    logic               init_done_q;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATAW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [NREQ-1:0]    gnt;
    logic [PW-1:0]      gnt_idx;
    logic               xfer;
    logic [ADDRW-1:0]   sel_addr;
    logic [3:0]         sel_we;
    logic [DATAW-1:0]   sel_wdata;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // rstn gates every combinational output so reset silences the SRAM and handshake at once
    assign xfer      = rstn && state_q == ST_RUN && |gnt;
    assign sel_addr  = bus.req_addr[int'(gnt_idx)*ADDRW +: ADDRW];
    assign sel_we    = bus.req_we[int'(gnt_idx)*BYTE_LANES +: BYTE_LANES];
    assign sel_wdata = bus.req_wdata[int'(gnt_idx)*DATAW +: DATAW];

    assign rr_ptr_d    = xfer ? ((int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1)) : rr_ptr_q;
    assign rsp_valid_d = xfer ? gnt : '0;
    assign rsp_rdata_d = xfer ? ((sel_we == WE_READ) ? bus.mem_rdata : '0) : rsp_rdata_q;

    assign bus.req_ready = xfer ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.init_done = init_done_q;

    // SRAM port: zero-fill writes during the sweep, otherwise the granted requester's fields
    always_comb begin
        bus.mem_cs    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = WE_READ;
        bus.mem_wdata = '0;
        if (rstn && state_q == ST_INIT && INIT_DEPTH != 0) begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = init_cnt_q;
            bus.mem_we   = WE_FULL;
        end else if (xfer) begin
            bus.mem_cs    = 1'b1;
            bus.mem_addr  = sel_addr;
            bus.mem_we    = sel_we;
            bus.mem_wdata = sel_wdata;
        end
    end

    // INIT sweep walks 0..INIT_DEPTH-1 once, then the FSM parks in RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + ADDRW'(1);
            if (INIT_DEPTH == 0 || init_cnt_q == ADDRW'(LAST)) begin
                state_q     <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end
    end

    // round-robin pointer and one-cycle response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sweep, access, byte merge, round-robin and reset
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.NREQ(2), .ADDRW(10)) bus ();

    sram_arbiter #(.NREQ(2), .ADDRW(10), .DATAW(32), .INIT_DEPTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] sram [1024];

    initial for (int i = 0; i < 1024; i++) sram[i] = 32'hA5A5_0000 | i;

    assign bus.mem_rdata = (bus.mem_cs && bus.mem_we == 4'h0) ? sram[bus.mem_addr] : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (bus.mem_cs)
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
        bus.req_addr[r*10 +: 10] = a;
        bus.req_we[r*4 +: 4]     = we;
        bus.req_wdata[r*32 +: 32] = d;
    endtask

    task automatic access(input string tag, input int r, input logic [9:0] a, input logic [3:0] we,
                          input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        set_req(r, a, we, d);
        bus.req_valid = 2'b01 << r;
        #1 chk({tag, "_ready"}, 32'(bus.req_ready), 32'(2'b01 << r));
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(2'b01 << r));
        chk({tag, "_rdata"}, bus.rsp_rdata, exp);
    endtask

    int          g [4]   = '{0, 1, 0, 1};
    logic [31:0] dat [2] = '{32'hDEADAAEF, 32'h1111_0000};

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_we    = '0;
        bus.req_wdata = '0;

        #2;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_rspv", 32'(bus.rsp_valid), 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_cs", 32'(bus.mem_cs), 0);
        chk("rst_done", 32'(bus.init_done), 0);

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("init_cs", 32'(bus.mem_cs), 1);
        chk("init_we", 32'(bus.mem_we), 32'hF);
        chk("init_addr0", 32'(bus.mem_addr), 0);
        repeat (15) @(posedge clk);
        #1 chk("init_done_15", 32'(bus.init_done), 0);
        @(posedge clk);
        #1 chk("init_done_16", 32'(bus.init_done), 1);
        for (int a = 0; a < 16; a++) access($sformatf("zero%0d", a), 0, 10'(a), 4'h0, 0, 0);
        access("rd16", 0, 10'd16, 4'h0, 0, 32'hA5A5_0010);

        access("wr5", 0, 10'd5, 4'hF, 32'hDEADBEEF, 0);
        access("rd5", 0, 10'd5, 4'h0, 0, 32'hDEADBEEF);
        access("wr5p", 0, 10'd5, 4'b0010, 32'h0000AA00, 0);
        access("rd5p", 0, 10'd5, 4'h0, 0, 32'hDEADAAEF);
        @(negedge clk);
        chk("hold_rspv", 32'(bus.rsp_valid), 0);
        chk("hold_rdata", bus.rsp_rdata, 32'hDEADAAEF);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("r1_rspv", 32'(bus.rsp_valid), 32'b10);
                chk("r1_ptr", 32'(dut.rr_ptr_q), 0);
            end
            set_req(1, 10'(8 + k), 4'hF, 32'h1111_0000 + k);
            bus.req_valid = 2'b10;
            #1 chk("r1_ready", 32'(bus.req_ready), 32'b10);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("r1_rspv_last", 32'(bus.rsp_valid), 32'b10);
        chk("r1_ptr_last", 32'(dut.rr_ptr_q), 0);
        access("rd9", 1, 10'd9, 4'h0, 0, 32'h1111_0001);
        access("rd10", 1, 10'd10, 4'h0, 0, 32'h1111_0002);

        @(negedge clk);
        set_req(0, 10'd5, 4'h0, 0);
        set_req(1, 10'd8, 4'h0, 0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(2'b01 << g[k]));
            @(negedge clk);
            chk($sformatf("rr_rspv%0d", k), 32'(bus.rsp_valid), 32'(2'b01 << g[k]));
            chk($sformatf("rr_rdata%0d", k), bus.rsp_rdata, dat[g[k]]);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("rr_idle_rspv", 32'(bus.rsp_valid), 0);

        @(negedge clk);
        set_req(0, 10'd5, 4'hF, 32'hFFFF_FFFF);
        bus.req_valid = 2'b01;
        @(negedge clk);
        #1;
        chk("mid_rspv", 32'(bus.rsp_valid), 32'b01);
        chk("mid_ready", 32'(bus.req_ready), 32'b01);
        rstn = 1'b0;
        #1;
        chk("arst_rspv", 32'(bus.rsp_valid), 0);
        chk("arst_ready", 32'(bus.req_ready), 0);
        chk("arst_cs", 32'(bus.mem_cs), 0);
        chk("arst_done", 32'(bus.init_done), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("re_ready", 32'(bus.req_ready), 0);
        chk("re_cs", 32'(bus.mem_cs), 1);
        chk("re_addr0", 32'(bus.mem_addr), 0);
        bus.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 chk("re_addr3", 32'(bus.mem_addr), 3);
        repeat (12) @(posedge clk);
        #1 chk("re_done_15", 32'(bus.init_done), 0);
        @(posedge clk);
        #1 chk("re_done_16", 32'(bus.init_done), 1);
        access("re_rd5", 0, 10'd5, 4'h0, 0, 0);
        access("re_rd8", 1, 10'd8, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
